// File: rtl/apb_cmd_master_pkg.sv
// Shared types and response codes for the APB command master.
package apb_cmd_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StGap,
    StResp
  } state_e;

  localparam logic [1:0] RSP_OK     = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b01;
  localparam logic [1:0] RSP_POLLX  = 2'b10;
  localparam logic [1:0] RSP_TMO    = 2'b11;

endpackage

// File: rtl/apb_cyc_cnt.sv
// Loadable down-counter with zero flag; holds at zero when decremented further.
module apb_cyc_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to single APB3 transfers, with optional read polling.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TIMEOUT_CYC cycles.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned POLL_MAX    = 16,
  parameter int unsigned POLL_GAP    = 2,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic              cmd_poll_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [DATA_W-1:0] cmd_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_code_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] PADDR_o,
  output logic [DATA_W-1:0] PWDATA_o,
  output logic              PWRITE_o,
  output logic              PSEL_o,
  output logic              PENABLE_o,
  input  logic [DATA_W-1:0] PRDATA_i,
  input  logic              PREADY_i,
  input  logic              PSLVERR_i
);

  localparam int unsigned CntMax = (TIMEOUT_CYC > POLL_GAP) ? TIMEOUT_CYC : POLL_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RdW    = $clog2(POLL_MAX + 1);
  localparam logic [RdW-1:0] ReadsMax = RdW'(POLL_MAX);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic                write_q, write_d;
  logic                poll_q, poll_d;
  logic [RdW-1:0]      reads_q, reads_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          code_q, code_d;
  logic                live_q;

  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CntW-1:0]     cnt_val;
  logic                poll_hit;

  // For a poll read the write-data field carries the match value.
  assign poll_hit = ((PRDATA_i & mask_q) == wdata_q);

  apb_cyc_cnt #(
    .Width(CntW)
  ) u_cyc_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    write_d  = write_q;
    poll_d   = poll_q;
    reads_d  = reads_q;
    rdata_d  = rdata_q;
    code_d   = code_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && live_q) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          mask_d  = cmd_mask_i;
          write_d = cmd_write_i;
          poll_d  = cmd_poll_i & ~cmd_write_i;
          reads_d = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
`ifdef APB_TIMEOUT_EN
        cnt_load = 1'b1;
        cnt_val  = CntW'(TIMEOUT_CYC - 1);
`endif
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY_i) begin
          reads_d = (reads_q == ReadsMax) ? reads_q : reads_q + RdW'(1);
          rdata_d = write_q ? '0 : PRDATA_i;
          if (PSLVERR_i) begin
            code_d  = RSP_SLVERR;
            state_d = StResp;
          end else if (!poll_q || poll_hit) begin
            code_d  = RSP_OK;
            state_d = StResp;
          end else if (reads_d == ReadsMax) begin
            code_d  = RSP_POLLX;
            state_d = StResp;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = CntW'(POLL_GAP - 1);
            state_d  = StGap;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_zero) begin
          code_d  = RSP_TMO;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      StGap: begin
        if (cnt_zero) begin
          state_d = StSetup;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      poll_q  <= 1'b0;
      reads_q <= '0;
      rdata_q <= '0;
      code_q  <= RSP_OK;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      write_q <= write_d;
      poll_q  <= poll_d;
      reads_q <= reads_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      live_q  <= 1'b1;
    end
  end

  // live_q keeps cmd_ready_o low while in reset so every output reads 0.
  assign cmd_ready_o = (state_q == StIdle) && live_q;
  assign busy_o      = (state_q != StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_code_o  = code_q;
  assign PADDR_o     = addr_q;
  assign PWDATA_o    = wdata_q;
  assign PWRITE_o    = write_q;
  assign PSEL_o      = (state_q == StSetup) || (state_q == StAccess);
  assign PENABLE_o   = (state_q == StAccess);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small reactive APB slave model.
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic        cmd_poll_i = 1'b0;
  logic [11:0] cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic [31:0] cmd_mask_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_code_o;
  logic        busy_o;
  logic [11:0] PADDR_o;
  logic [31:0] PWDATA_o;
  logic        PWRITE_o;
  logic        PSEL_o;
  logic        PENABLE_o;
  logic [31:0] PRDATA_i;
  logic        PREADY_i;
  logic        PSLVERR_i;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  apb_cmd_master dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_poll_i  (cmd_poll_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_mask_i  (cmd_mask_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_code_o  (rsp_code_o),
    .busy_o      (busy_o),
    .PADDR_o     (PADDR_o),
    .PWDATA_o    (PWDATA_o),
    .PWRITE_o    (PWRITE_o),
    .PSEL_o      (PSEL_o),
    .PENABLE_o   (PENABLE_o),
    .PRDATA_i    (PRDATA_i),
    .PREADY_i    (PREADY_i),
    .PSLVERR_i   (PSLVERR_i)
  );

  // Slave: PREADY after slv_wait stalled ACCESS cycles; bit 0 of PRDATA rises on read rise_at.
  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic        slv_err_wait = 1'b0;
  logic [31:0] slv_data = '0;
  int          rise_at = 0;
  int          acc_cyc = 0;
  int          read_cnt = 0;
  logic        in_access;

  assign in_access = PSEL_o && PENABLE_o;
  assign PREADY_i  = in_access && (acc_cyc >= slv_wait);
  assign PSLVERR_i = PREADY_i ? slv_err : (in_access && slv_err_wait);
  assign PRDATA_i  = slv_data | (((rise_at != 0) && (read_cnt + 1 >= rise_at)) ? 32'h1 : 32'h0);

  always @(posedge clk) begin
    if (in_access && !PREADY_i) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
    if (PREADY_i) read_cnt <= read_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge while idle; returns one cycle after acceptance (cycle N+1).
  task automatic issue(input logic wr, input logic poll, input logic [11:0] a,
                       input logic [31:0] wd, input logic [31:0] mk);
    cmd_write_i = wr;
    cmd_poll_i  = poll;
    cmd_addr_i  = a;
    cmd_wdata_i = wd;
    cmd_mask_i  = mk;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  // lat is cycles from acceptance to rsp_valid_o; gaps counts busy cycles with PSEL low.
  task automatic wait_rsp(input logic [11:0] ea, output int lat, output int gaps,
                          output logic addr_bad);
    lat = 1;
    gaps = 0;
    addr_bad = 1'b0;
    while (!rsp_valid_o && lat < 3000) begin
      if (!PSEL_o && busy_o) gaps++;
      if (PSEL_o && (PADDR_o !== ea)) addr_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int   lat;
    int   gaps;
    int   base;
    logic bad;
    logic seen;

    // Reset state
    #1;
    chk("rst_psel", PSEL_o, 0);
    chk("rst_penable", PENABLE_o, 0);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_paddr", PADDR_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1. Zero-wait write
    cmd_write_i = 1'b1;
    cmd_poll_i  = 1'b0;
    cmd_addr_i  = 12'h010;
    cmd_wdata_i = 32'hDEADBEEF;
    cmd_mask_i  = '0;
    cmd_valid_i = 1'b1;
    chk("t1_ready", cmd_ready_o, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("t1_setup_psel", PSEL_o, 1);
    chk("t1_setup_pen", PENABLE_o, 0);
    chk("t1_paddr", PADDR_o, 32'h010);
    chk("t1_pwdata", PWDATA_o, 32'hDEADBEEF);
    chk("t1_pwrite", PWRITE_o, 1);
    @(negedge clk);
    chk("t1_access_psel", PSEL_o, 1);
    chk("t1_access_pen", PENABLE_o, 1);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid_o, 1);
    chk("t1_code", rsp_code_o, 2'b00);
    chk("t1_rdata", rsp_rdata_o, 0);
    chk("t1_resp_psel", PSEL_o, 0);
    consume();
    chk("t1_rsp_clear", rsp_valid_o, 0);
    chk("t1_ready_again", cmd_ready_o, 1);

    // 2. Read with 3 wait states; PSLVERR high during waits must be ignored
    slv_wait = 3;
    slv_err_wait = 1'b1;
    slv_data = 32'h12345678;
    issue(1'b0, 1'b0, 12'h014, 32'h0, 32'h0);
    wait_rsp(12'h014, lat, gaps, bad);
    chk("t2_latency", lat, 6);
    chk("t2_addr_stable", bad, 0);
    chk("t2_code", rsp_code_o, 2'b00);
    chk("t2_rdata", rsp_rdata_o, 32'h12345678);
    chk("t2_pwrite", PWRITE_o, 0);
    consume();
    slv_err_wait = 1'b0;

    // 3. Read completing with PSLVERR
    slv_wait = 2;
    slv_err = 1'b1;
    slv_data = 32'hCAFE0001;
    issue(1'b0, 1'b0, 12'h020, 32'h0, 32'h0);
    wait_rsp(12'h020, lat, gaps, bad);
    chk("t3_latency", lat, 5);
    chk("t3_code", rsp_code_o, 2'b01);
    chk("t3_rdata", rsp_rdata_o, 32'hCAFE0001);
    consume();
    slv_err = 1'b0;

    // 4a. Poll; status bit rises on the 3rd read
    slv_wait = 0;
    slv_data = 32'h00000F00;
    base = read_cnt;
    rise_at = read_cnt + 3;
    issue(1'b0, 1'b1, 12'h004, 32'h1, 32'h1);
    wait_rsp(12'h004, lat, gaps, bad);
    chk("t4a_latency", lat, 11);
    chk("t4a_gap_cycles", gaps, 4);
    chk("t4a_reads", read_cnt - base, 3);
    chk("t4a_code", rsp_code_o, 2'b00);
    chk("t4a_rdata", rsp_rdata_o, 32'h00000F01);
    consume();

    // 4b. Poll; never matches
    rise_at = 0;
    base = read_cnt;
    issue(1'b0, 1'b1, 12'h004, 32'h1, 32'h1);
    wait_rsp(12'h004, lat, gaps, bad);
    chk("t4b_latency", lat, 63);
    chk("t4b_reads", read_cnt - base, 16);
    chk("t4b_gap_cycles", gaps, 30);
    chk("t4b_code", rsp_code_o, 2'b10);
    chk("t4b_rdata", rsp_rdata_o, 32'h00000F00);
    consume();

    // 5. Response back-pressure; a pending command is not taken on the handshake cycle
    slv_data = 32'h55AA55AA;
    issue(1'b0, 1'b0, 12'h030, 32'h0, 32'h0);
    wait_rsp(12'h030, lat, gaps, bad);
    cmd_write_i = 1'b1;
    cmd_poll_i  = 1'b0;
    cmd_addr_i  = 12'h034;
    cmd_wdata_i = 32'h0BADF00D;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", rsp_valid_o, 1);
      chk("t5_hold_rdata", rsp_rdata_o, 32'h55AA55AA);
      chk("t5_hold_code", rsp_code_o, 2'b00);
      chk("t5_hold_cmd_ready", cmd_ready_o, 0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("t5_idle_after_hs", cmd_ready_o, 1);
    chk("t5_no_setup_on_hs", PSEL_o, 0);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("t5_next_psel", PSEL_o, 1);
    chk("t5_next_paddr", PADDR_o, 32'h034);
    wait_rsp(12'h034, lat, gaps, bad);
    chk("t5_next_code", rsp_code_o, 2'b00);
    chk("t5_next_rdata", rsp_rdata_o, 0);
    consume();

    // 5b. Asynchronous reset during ACCESS
    slv_wait = 1000000;
    issue(1'b0, 1'b0, 12'h040, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5r_in_access", PENABLE_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_psel_async", PSEL_o, 0);
    chk("t5r_pen_async", PENABLE_o, 0);
    chk("t5r_busy_async", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    slv_wait = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o || PSEL_o) seen = 1'b1;
      @(negedge clk);
    end
    chk("t5r_no_rsp", seen, 0);
    chk("t5r_ready", cmd_ready_o, 1);

    // 6. PREADY stuck low
    slv_wait = 1000000;
    issue(1'b0, 1'b0, 12'h050, 32'h0, 32'h0);
`ifdef APB_TIMEOUT_EN
    wait_rsp(12'h050, lat, gaps, bad);
    chk("t6_latency", lat, 258);
    chk("t6_code", rsp_code_o, 2'b11);
    chk("t6_rdata", rsp_rdata_o, 0);
    chk("t6_psel", PSEL_o, 0);
    consume();
`else
    repeat (998) @(negedge clk);
    chk("t6_psel", PSEL_o, 1);
    chk("t6_penable", PENABLE_o, 1);
    chk("t6_busy", busy_o, 1);
    chk("t6_no_rsp", rsp_valid_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    slv_wait = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
